// File: rtl/sel_encode_pkg.sv
// Shared constants, field-select enum and helpers for the register select/encode stage.
package sel_encode_pkg;

  localparam int DEF_NUM_REGS = 16;
  localparam int DEF_IDX_W    = 4;
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_RA_LSB   = 23;
  localparam int DEF_RB_LSB   = 19;
  localparam int DEF_RC_LSB   = 15;
  localparam int DEF_CONST_W  = 19;

  typedef enum logic [1:0] {
    FIELD_NONE = 2'd0,
    FIELD_A    = 2'd1,
    FIELD_B    = 2'd2,
    FIELD_C    = 2'd3
  } field_sel_e;

  // Sign-extend the low C field of an instruction word (default geometry).
  function automatic logic [DEF_DATA_W-1:0] sext_const(input logic [DEF_DATA_W-1:0] word);
    sext_const = {{(DEF_DATA_W-DEF_CONST_W){word[DEF_CONST_W-1]}}, word[DEF_CONST_W-1:0]};
  endfunction

  function automatic logic [DEF_NUM_REGS-1:0] onehot(input logic [DEF_IDX_W-1:0] idx);
    onehot = {DEF_NUM_REGS{1'b0}};
    onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/sel_encode_unit_if.sv
// Control-side strobes in, register-file strobes and IR/constant out.
// multi_sel_err exists only when SEL_ENCODE_MULTI_SEL_CHECK_EN is defined.
interface sel_encode_unit_if #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  parameter int IDX_W    = 4
);
  logic              ir_load;
  logic [DATA_W-1:0] ir_in;
  logic              gra;
  logic              grb;
  logic              grc;
  logic              r_in;
  logic              r_out;
  logic              ba_out;

  logic [DATA_W-1:0]   ir_q;
  logic [DATA_W-1:0]   c_sign_extended;
  logic [IDX_W-1:0]    sel_idx;
  logic [NUM_REGS-1:0] reg_in;
  logic [NUM_REGS-1:0] reg_out;
  logic                ba_zero;
  logic                sel_range_err;
`ifdef SEL_ENCODE_MULTI_SEL_CHECK_EN
  logic                multi_sel_err;
`endif

  modport slave (
    input  ir_load, ir_in, gra, grb, grc, r_in, r_out, ba_out,
    output ir_q, c_sign_extended, sel_idx, reg_in, reg_out, ba_zero, sel_range_err
`ifdef SEL_ENCODE_MULTI_SEL_CHECK_EN
    , output multi_sel_err
`endif
  );

  modport master (
    output ir_load, ir_in, gra, grb, grc, r_in, r_out, ba_out,
    input  ir_q, c_sign_extended, sel_idx, reg_in, reg_out, ba_zero, sel_range_err
`ifdef SEL_ENCODE_MULTI_SEL_CHECK_EN
    , input multi_sel_err
`endif
  );

endinterface

// File: rtl/sel_encode_unit_onehot_decoder.sv
// Index to one-hot decoder with enable; valid flags indices inside the register file.
module onehot_decoder #(
  parameter int IDX_W    = 4,
  parameter int NUM_REGS = 16
) (
  input  logic [IDX_W-1:0]    idx,
  input  logic                en,
  output logic [NUM_REGS-1:0] hot,
  output logic                valid
);
  import sel_encode_pkg::*;

  // Out-of-range indices never produce a strobe.
  always_comb begin
    valid = (32'(idx) < NUM_REGS);
    hot   = {NUM_REGS{1'b0}};
    for (int i = 0; i < NUM_REGS; i++) begin
      if (en && valid && (32'(idx) == i)) begin
        hot[i] = 1'b1;
      end else begin
        hot[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/sel_encode_unit.sv
// Register select/encode stage: internal IR, Ra/Rb/Rc selection, registered one-hot strobes.
// Optional SEL_ENCODE_MULTI_SEL_CHECK_EN adds a sticky multi_sel_err flag.
module sel_encode_unit
  import sel_encode_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int IDX_W    = DEF_IDX_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int RA_LSB   = DEF_RA_LSB,
  parameter int RB_LSB   = DEF_RB_LSB,
  parameter int RC_LSB   = DEF_RC_LSB,
  parameter int CONST_W  = DEF_CONST_W
) (
  input  logic             clk,
  input  logic             reset,
  sel_encode_unit_if.slave bus
);

  logic [DATA_W-1:0]   ir_d, ir_q;
  logic [DATA_W-1:0]   c_d, c_q;
  logic [IDX_W-1:0]    sel_idx_d, sel_idx_q;
  logic [NUM_REGS-1:0] reg_in_d, reg_in_q;
  logic [NUM_REGS-1:0] reg_out_d, reg_out_q;
  logic                ba_zero_d, ba_zero_q;
  logic                range_err_d, range_err_q;

  field_sel_e          field;
  logic [IDX_W-1:0]    idx;
  logic                any_g;
  logic                idx_is_zero;
  logic [NUM_REGS-1:0] in_hot, out_hot;
  logic                in_valid, out_valid;

  // IR capture; the constant is extended from the incoming word so both update together.
  always_comb begin
    if (bus.ir_load) begin
      ir_d = bus.ir_in;
      c_d  = {{(DATA_W-CONST_W){bus.ir_in[CONST_W-1]}}, bus.ir_in[CONST_W-1:0]};
    end else begin
      ir_d = ir_q;
      c_d  = c_q;
    end
  end

  // Field priority gra > grb > grc, operands always from the current (old) IR.
  always_comb begin
    any_g = bus.gra | bus.grb | bus.grc;
    if (bus.gra) begin
      field = FIELD_A;
    end else if (bus.grb) begin
      field = FIELD_B;
    end else if (bus.grc) begin
      field = FIELD_C;
    end else begin
      field = FIELD_NONE;
    end
    case (field)
      FIELD_A: idx = ir_q[RA_LSB +: IDX_W];
      FIELD_B: idx = ir_q[RB_LSB +: IDX_W];
      FIELD_C: idx = ir_q[RC_LSB +: IDX_W];
      default: idx = {IDX_W{1'b0}};
    endcase
    idx_is_zero = (idx == {IDX_W{1'b0}});
  end

  onehot_decoder #(.IDX_W(IDX_W), .NUM_REGS(NUM_REGS)) u_dec_in (
    .idx   (idx),
    .en    (any_g & bus.r_in),
    .hot   (in_hot),
    .valid (in_valid)
  );

  onehot_decoder #(.IDX_W(IDX_W), .NUM_REGS(NUM_REGS)) u_dec_out (
    .idx   (idx),
    .en    (any_g & (bus.r_out | bus.ba_out)),
    .hot   (out_hot),
    .valid (out_valid)
  );

  // R0 read under ba_out becomes a bus zero instead of a register-file strobe.
  always_comb begin
    sel_idx_d   = idx;
    reg_in_d    = in_hot;
    reg_out_d   = out_hot;
    ba_zero_d   = bus.ba_out & any_g & idx_is_zero;
    range_err_d = any_g & ~(in_valid & out_valid);
    if (bus.ba_out && idx_is_zero) begin
      reg_out_d[0] = 1'b0;
    end else begin
      reg_out_d[0] = out_hot[0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ir_q        <= {DATA_W{1'b0}};
      c_q         <= {DATA_W{1'b0}};
      sel_idx_q   <= {IDX_W{1'b0}};
      reg_in_q    <= {NUM_REGS{1'b0}};
      reg_out_q   <= {NUM_REGS{1'b0}};
      ba_zero_q   <= 1'b0;
      range_err_q <= 1'b0;
    end else begin
      ir_q        <= ir_d;
      c_q         <= c_d;
      sel_idx_q   <= sel_idx_d;
      reg_in_q    <= reg_in_d;
      reg_out_q   <= reg_out_d;
      ba_zero_q   <= ba_zero_d;
      range_err_q <= range_err_d;
    end
  end

  assign bus.ir_q            = ir_q;
  assign bus.c_sign_extended = c_q;
  assign bus.sel_idx         = sel_idx_q;
  assign bus.reg_in          = reg_in_q;
  assign bus.reg_out         = reg_out_q;
  assign bus.ba_zero         = ba_zero_q;
  assign bus.sel_range_err   = range_err_q;

`ifdef SEL_ENCODE_MULTI_SEL_CHECK_EN
  logic multi_sel_d, multi_sel_q;

  // Sticky: once two field strobes collide, the flag holds until reset.
  always_comb begin
    multi_sel_d = multi_sel_q | (bus.gra & bus.grb) | (bus.gra & bus.grc) | (bus.grb & bus.grc);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      multi_sel_q <= 1'b0;
    end else begin
      multi_sel_q <= multi_sel_d;
    end
  end

  assign bus.multi_sel_err = multi_sel_q;
`endif

endmodule

// File: tb/tb_sel_encode_unit.sv
// Directed bench for sel_encode_unit: a default 16-register instance and a 12-register instance.
module tb_sel_encode_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        ir_load;
  logic [31:0] ir_in;
  logic        gra, grb, grc, r_in, r_out, ba_out;
  int          pass_cnt = 0;
  int          chk_cnt  = 0;

  always #5 clk = ~clk;

  sel_encode_unit_if #(.DATA_W(32), .NUM_REGS(16), .IDX_W(4)) if16 ();
  sel_encode_unit_if #(.DATA_W(32), .NUM_REGS(12), .IDX_W(4)) if12 ();

  assign if16.ir_load = ir_load; assign if12.ir_load = ir_load;
  assign if16.ir_in   = ir_in;   assign if12.ir_in   = ir_in;
  assign if16.gra     = gra;     assign if12.gra     = gra;
  assign if16.grb     = grb;     assign if12.grb     = grb;
  assign if16.grc     = grc;     assign if12.grc     = grc;
  assign if16.r_in    = r_in;    assign if12.r_in    = r_in;
  assign if16.r_out   = r_out;   assign if12.r_out   = r_out;
  assign if16.ba_out  = ba_out;  assign if12.ba_out  = ba_out;

  sel_encode_unit #(.NUM_REGS(16)) dut16 (.clk(clk), .reset(reset), .bus(if16.slave));
  sel_encode_unit #(.NUM_REGS(12)) dut12 (.clk(clk), .reset(reset), .bus(if12.slave));

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ir_load = 1'b0; ir_in = 32'h0000_0000;
    gra = 1'b0; grb = 1'b0; grc = 1'b0; r_in = 1'b0; r_out = 1'b0; ba_out = 1'b0;
  endtask

  task automatic load_ir(input logic [31:0] w);
    idle(); ir_load = 1'b1; ir_in = w;
    cyc();
    idle();
  endtask

  task automatic test_reset();
    reset = 1'b1; ir_load = 1'b1; ir_in = 32'hFFFF_FFFF;
    gra = 1'b1; grb = 1'b1; grc = 1'b1; r_in = 1'b1; r_out = 1'b1; ba_out = 1'b1;
    cyc(); cyc();
    chk_cnt++; if (if16.ir_q !== 32'h0) $display("FAIL rst_ir got %h exp 0", if16.ir_q); else pass_cnt++;
    chk_cnt++; if (if16.c_sign_extended !== 32'h0) $display("FAIL rst_c got %h exp 0", if16.c_sign_extended); else pass_cnt++;
    chk_cnt++; if (if16.sel_idx !== 4'h0) $display("FAIL rst_idx got %h exp 0", if16.sel_idx); else pass_cnt++;
    chk_cnt++; if (if16.reg_in !== 16'h0 || if16.reg_out !== 16'h0) $display("FAIL rst_strobes got %h/%h exp 0/0", if16.reg_in, if16.reg_out); else pass_cnt++;
    chk_cnt++; if (if16.ba_zero !== 1'b0 || if16.sel_range_err !== 1'b0) $display("FAIL rst_flags got %b%b exp 00", if16.ba_zero, if16.sel_range_err); else pass_cnt++;
    chk_cnt++; if (if12.reg_in !== 12'h0 || if12.sel_range_err !== 1'b0) $display("FAIL rst12 got %h/%b exp 0/0", if12.reg_in, if12.sel_range_err); else pass_cnt++;
`ifdef SEL_ENCODE_MULTI_SEL_CHECK_EN
    chk_cnt++; if (if16.multi_sel_err !== 1'b0) $display("FAIL rst_multi got %b exp 0", if16.multi_sel_err); else pass_cnt++;
`endif
    reset = 1'b0; idle();
    load_ir(32'h0123_4567);
    chk_cnt++; if (if16.ir_q !== 32'h0123_4567) $display("FAIL load_ir got %h exp 01234567", if16.ir_q); else pass_cnt++;
    chk_cnt++; if (if16.c_sign_extended !== 32'h0003_4567) $display("FAIL sext_pos got %h exp 00034567", if16.c_sign_extended); else pass_cnt++;
    cyc();
    chk_cnt++; if (if16.ir_q !== 32'h0123_4567) $display("FAIL ir_hold got %h exp 01234567", if16.ir_q); else pass_cnt++;
  endtask

  task automatic test_sext();
    load_ir(32'h0004_0000);
    chk_cnt++; if (if16.c_sign_extended !== 32'hFFFC_0000) $display("FAIL sext_neg got %h exp FFFC0000", if16.c_sign_extended); else pass_cnt++;
  endtask

  task automatic test_select();
    load_ir(32'h029C_8000); // Ra=5 Rb=3 Rc=9
    chk_cnt++; if (if16.c_sign_extended !== 32'hFFFC_8000) $display("FAIL sext_sel got %h exp FFFC8000", if16.c_sign_extended); else pass_cnt++;
    gra = 1'b1; r_in = 1'b1; cyc(); idle();
    chk_cnt++; if (if16.reg_in !== 16'h0020 || if16.reg_out !== 16'h0) $display("FAIL gra_rin got %h/%h exp 0020/0000", if16.reg_in, if16.reg_out); else pass_cnt++;
    chk_cnt++; if (if16.sel_idx !== 4'd5) $display("FAIL gra_idx got %0d exp 5", if16.sel_idx); else pass_cnt++;
    grb = 1'b1; r_out = 1'b1; cyc(); idle();
    chk_cnt++; if (if16.reg_out !== 16'h0008 || if16.reg_in !== 16'h0) $display("FAIL grb_rout got %h/%h exp 0000/0008", if16.reg_in, if16.reg_out); else pass_cnt++;
    grc = 1'b1; r_in = 1'b1; r_out = 1'b1; cyc(); idle();
    chk_cnt++; if (if16.reg_in !== 16'h0200 || if16.reg_out !== 16'h0200 || if16.sel_idx !== 4'd9) $display("FAIL grc_both got %h/%h/%0d exp 0200/0200/9", if16.reg_in, if16.reg_out, if16.sel_idx); else pass_cnt++;
    grb = 1'b1; grc = 1'b1; r_in = 1'b1; cyc(); idle();
    chk_cnt++; if (if16.reg_in !== 16'h0008) $display("FAIL prio_b_over_c got %h exp 0008", if16.reg_in); else pass_cnt++;
    r_in = 1'b1; r_out = 1'b1; cyc(); idle();
    chk_cnt++; if (if16.reg_in !== 16'h0 || if16.reg_out !== 16'h0 || if16.sel_idx !== 4'd0) $display("FAIL no_field got %h/%h/%0d exp 0/0/0", if16.reg_in, if16.reg_out, if16.sel_idx); else pass_cnt++;
    cyc();
    chk_cnt++; if (if16.reg_in !== 16'h0 || if16.reg_out !== 16'h0) $display("FAIL no_sticky got %h/%h exp 0/0", if16.reg_in, if16.reg_out); else pass_cnt++;
  endtask

  task automatic test_ba_out();
    load_ir(32'h0000_0000);
    gra = 1'b1; ba_out = 1'b1; cyc(); idle();
    chk_cnt++; if (if16.reg_out !== 16'h0 || if16.ba_zero !== 1'b1) $display("FAIL ba_r0 got %h/%b exp 0000/1", if16.reg_out, if16.ba_zero); else pass_cnt++;
    ba_out = 1'b1; cyc(); idle();
    chk_cnt++; if (if16.ba_zero !== 1'b0) $display("FAIL ba_nofield got %b exp 0", if16.ba_zero); else pass_cnt++;
    load_ir(32'h0100_0000); // Ra=2
    gra = 1'b1; ba_out = 1'b1; cyc(); idle();
    chk_cnt++; if (if16.reg_out !== 16'h0004 || if16.ba_zero !== 1'b0) $display("FAIL ba_r2 got %h/%b exp 0004/0", if16.reg_out, if16.ba_zero); else pass_cnt++;
  endtask

  task automatic test_range();
    load_ir(32'h0007_0000); // Rc=14, Ra=0
    grc = 1'b1; r_in = 1'b1; r_out = 1'b1; cyc(); idle();
    chk_cnt++; if (if12.reg_in !== 12'h0 || if12.reg_out !== 12'h0 || if12.sel_range_err !== 1'b1) $display("FAIL range12 got %h/%h/%b exp 000/000/1", if12.reg_in, if12.reg_out, if12.sel_range_err); else pass_cnt++;
    chk_cnt++; if (if16.reg_in !== 16'h4000 || if16.sel_range_err !== 1'b0) $display("FAIL range16 got %h/%b exp 4000/0", if16.reg_in, if16.sel_range_err); else pass_cnt++;
    cyc();
    chk_cnt++; if (if12.sel_range_err !== 1'b0) $display("FAIL range_clear got %b exp 0", if12.sel_range_err); else pass_cnt++;
    load_ir(32'h0005_8000); // Rc=11, last legal index for 12 regs
    grc = 1'b1; r_in = 1'b1; cyc(); idle();
    chk_cnt++; if (if12.reg_in !== 12'h800 || if12.sel_range_err !== 1'b0) $display("FAIL range_edge got %h/%b exp 800/0", if12.reg_in, if12.sel_range_err); else pass_cnt++;
    load_ir(32'h0007_0000);
    ir_load = 1'b1; ir_in = 32'h0180_0000; gra = 1'b1; r_in = 1'b1; cyc(); idle();
    chk_cnt++; if (if16.reg_in !== 16'h0001 || if16.sel_idx !== 4'd0) $display("FAIL load_sel_old got %h/%0d exp 0001/0", if16.reg_in, if16.sel_idx); else pass_cnt++;
    chk_cnt++; if (if16.ir_q !== 32'h0180_0000) $display("FAIL load_sel_ir got %h exp 01800000", if16.ir_q); else pass_cnt++;
    gra = 1'b1; r_in = 1'b1; cyc(); idle();
    chk_cnt++; if (if16.reg_in !== 16'h0008) $display("FAIL load_sel_new got %h exp 0008", if16.reg_in); else pass_cnt++;
  endtask

`ifdef SEL_ENCODE_MULTI_SEL_CHECK_EN
  task automatic test_multi_sel();
    load_ir(32'h0083_8000); // Ra=1 Rc=7
    chk_cnt++; if (if16.multi_sel_err !== 1'b0) $display("FAIL multi_pre got %b exp 0", if16.multi_sel_err); else pass_cnt++;
    gra = 1'b1; grc = 1'b1; r_in = 1'b1; cyc(); idle();
    chk_cnt++; if (if16.reg_in !== 16'h0002 || if16.multi_sel_err !== 1'b1) $display("FAIL multi_set got %h/%b exp 0002/1", if16.reg_in, if16.multi_sel_err); else pass_cnt++;
    cyc(); cyc();
    chk_cnt++; if (if16.multi_sel_err !== 1'b1) $display("FAIL multi_sticky got %b exp 1", if16.multi_sel_err); else pass_cnt++;
    reset = 1'b1; cyc(); reset = 1'b0;
    chk_cnt++; if (if16.multi_sel_err !== 1'b0) $display("FAIL multi_rst got %b exp 0", if16.multi_sel_err); else pass_cnt++;
  endtask
`endif

  initial begin
    reset = 1'b1;
    idle();
    test_reset();
    test_sext();
    test_select();
    test_ba_out();
    test_range();
`ifdef SEL_ENCODE_MULTI_SEL_CHECK_EN
    test_multi_sel();
`endif
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/sel_encode_unit.md
Name: sel_encode_unit

Overview:
- Parametrised register-select and encode stage for the datapath control path.
- Holds its own instruction register and extracts the Ra/Rb/Rc fields.
- Produces registered one-hot register-file in/out strobes and a sign-extended C constant.
- Sits between the control unit (G*/Rin/Rout/BAout strobes) and the register file and bus mux; replaces the fixed 16-register select/encode logic.

Parameters:
- NUM_REGS, 16, number of general registers; one-hot strobe width.
- IDX_W, 4, register-field width; must satisfy 2**IDX_W >= NUM_REGS.
- DATA_W, 32, instruction and constant width.
- RA_LSB, 23, LSB of the Ra field in the instruction.
- RB_LSB, 19, LSB of the Rb field.
- RC_LSB, 15, LSB of the Rc field.
- CONST_W, 19, width of the C constant field, taken at instruction [CONST_W-1:0]; its MSB is the sign bit.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- ir_load  in  1  capture ir_in into the internal IR.
- ir_in  in  DATA_W  instruction word from the bus.
- gra, grb, grc  in  1 each  field-select strobes.
- r_in, r_out, ba_out  in  1 each  write / read / base-address-read strobes.
- ir_q  out  DATA_W  current IR contents.
- c_sign_extended  out  DATA_W  sign-extended C field.
- sel_idx  out  IDX_W  registered selected register index.
- reg_in  out  NUM_REGS  one-hot write strobe.
- reg_out  out  NUM_REGS  one-hot read strobe.
- ba_zero  out  1  drive zero onto the bus in place of R0.
- sel_range_err  out  1  selected index is >= NUM_REGS.

Behaviour:
- Reset (sync): ir_q, c_sign_extended, sel_idx, reg_in, reg_out, ba_zero and sel_range_err all go to 0. Reset has priority over every other input, including mid-sequence.
- IR stage:
  - On ir_load: ir_q <= ir_in; c_sign_extended <= {(DATA_W-CONST_W){ir_in[CONST_W-1]}, ir_in[CONST_W-1:0]}.
  - Otherwise both hold.
- Select stage (every cycle, operands from ir_q):
  - Field priority: gra > grb > grc. The first asserted field selects the index.
  - No field strobe asserted: index 0 and no strobes.
- Registered outputs (latency 1 from the G*/R* strobes):
  - sel_idx <= index.
  - reg_in <= onehot(index) when r_in and index < NUM_REGS.
  - reg_out <= onehot(index) when (r_out | ba_out) and index < NUM_REGS, except bit 0 is suppressed when ba_out is asserted and index == 0.
  - ba_zero <= ba_out & (index == 0) & field strobe asserted.
  - sel_range_err <= field strobe asserted & (index >= NUM_REGS). Both strobes are forced to 0 in that cycle.
- Simultaneous ir_load and G* in the same cycle: selection uses the OLD ir_q. The new IR is visible one cycle later.
- r_in and r_out asserted together: both reg_in and reg_out carry the same one-hot bit. Legal; the bench checks it.
- At most one bit of reg_in and one bit of reg_out may be high in any cycle.
- Strobes last exactly one cycle per cycle of input assertion; no stickiness.

Optional Feature:
- Macro SEL_ENCODE_MULTI_SEL_CHECK_EN.
- Defined:
  - Adds output multi_sel_err (1 bit), registered.
  - Set when two or more of gra/grb/grc are high in the same cycle.
  - Sticky until reset.
  - Priority selection still applies.
- Undefined: port is absent; multiple G strobes are resolved silently by priority.

Decomposition:
- Package sel_encode_pkg:
  - Default field LSB constants (RA_LSB, RB_LSB, RC_LSB).
  - CONST_W default.
  - Function sext_const(word) returning the sign-extended constant.
  - Function onehot(idx) returning a NUM_REGS-wide vector.
- One sub-module: onehot_decoder (IDX_W -> NUM_REGS, with enable and range-valid output), instantiated twice, for in and out.

Test Plan:
- reset=1 for 2 cycles with every strobe high -> all outputs 0. Release reset, ir_load with ir_in=32'h0123_4567 -> next cycle ir_q=32'h0123_4567 and c_sign_extended=32'h0003_4567.
- ir_in=32'h0004_0000 (C sign bit set), ir_load -> c_sign_extended=32'hFFFC_0000.
- IR with Ra=5, Rb=3, Rc=9; gra & r_in one cycle -> next cycle reg_in=16'h0020, reg_out=0, sel_idx=5. Then grb & r_out -> reg_out=16'h0008.
- Ra=0, gra & ba_out -> reg_out=0, ba_zero=1. Same with Ra=2 -> reg_out=16'h0004, ba_zero=0.
- NUM_REGS=12, Rc=14, grc & r_in -> reg_in=0, sel_range_err=1. Same cycle ir_load & gra -> selection uses the previous IR value.
- With SEL_ENCODE_MULTI_SEL_CHECK_EN: gra & grc with Ra=1, Rc=7, r_in -> reg_in=16'h0002, multi_sel_err=1 and stays 1 until reset.
